mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single RAM port of the multi-cycle MIPS CPU between the instruction-fetch path (NPC/IR)
//  and the data path (MAR/MDR). Arbitrates the two requesters, sequences the RAM access over a fixed
//  number of wait cycles, and returns read data with a one-cycle acknowledge. Sits between the
//  control unit's fetch/load/store requests and the RAM module.
// PARAMETERS
//  ADDR_W     9   byte-address width of the RAM
//  DATA_W     32  data width
//  MEM_LAT    2   cycles mem_en is held per access (>=1)
//  STARVE_MAX 4   consecutive fetch losses before fetch is forced to win (>=1)
// PORTS
//  clk        in   1       system clock; all state updates on rising edge
//  reset      in   1       synchronous, active-high reset
//  if_req     in   1       fetch request (level; held until if_ack)
//  if_addr    in   ADDR_W  fetch address (word read)
//  if_ack     out  1       one-cycle pulse: fetch done, if_rdata valid
//  if_rdata   out  DATA_W  fetched word, held until next if_ack
//  d_req      in   1       data request (level; held until d_ack)
//  d_we       in   1       1=store, 0=load
//  d_size     in   2       00=byte, 01=half, 10=word (11 treated as word)
//  d_addr     in   ADDR_W  data byte address
//  d_wdata    in   DATA_W  store data
//  d_ack      out  1       one-cycle pulse: data access done
//  d_err      out  1       valid with d_ack: misaligned access, no RAM cycle performed
//  d_rdata    out  DATA_W  load data, held until next d_ack
//  mem_en     out  1       RAM enable
//  mem_rw     out  1       1=write, 0=read
//  mem_size   out  2       access size forwarded to RAM
//  mem_addr   out  ADDR_W  RAM address
//  mem_wdata  out  DATA_W  RAM write data
//  mem_rdata  in   DATA_W  RAM read data, valid on last access cycle
//  busy       out  1       high in ACCESS and ACK states
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, starve_cnt=0, wait counter=0; reset mid-access aborts it, no ack.
//  - FSM IDLE -> ACCESS -> ACK -> IDLE; misaligned data request goes IDLE -> ACK directly.
//  - IDLE: sample requests; if none, stay. Only d_req: grant data. Only if_req: grant fetch.
//    Both: grant data unless starve_cnt==STARVE_MAX, then grant fetch.
//  - starve_cnt: +1 (saturating at STARVE_MAX) when both request and data wins; cleared on fetch grant.
//  - On grant, address/size/wdata/we latched into internal regs; mem_* driven from latches only,
//    stable for the whole ACCESS state regardless of requester inputs.
//  - Fetch grant forces mem_rw=0, mem_size=10.
//  - ACCESS: mem_en=1 for exactly MEM_LAT cycles; mem_rdata captured at the edge ending the last cycle.
//  - ACK (1 cycle): mem_en=0; pulse ack of granted port; rdata of that port updated (store: unchanged).
//  - Grant edge N -> ack asserted in cycle N+MEM_LAT+1; minimum transaction period MEM_LAT+2 cycles.
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0 -> no mem_en, ACK with d_err=1.
//    Fetch address low bits ignored (forced to 00 on mem_addr).
//  - Requester dropping req before ack: access still completes and ack still pulses (no abort).
//  - Requester must drop/renew req in the cycle after ack; a req still high in IDLE is a new request.
//  - Never both acks in one cycle; d_err=0 whenever d_ack=0.
// TESTING
//  1 Reset mid-ACCESS (d_req, addr 0x010) -> next cycle IDLE, mem_en=0, no d_ack, d_rdata=0.
//  2 if_req alone, if_addr=0x004, mem_rdata=0x8C220004 -> mem_en cycles 1-2, if_ack cycle 3,
//    if_rdata=0x8C220004, mem_rw=0, mem_size=10.
//  3 if_req and d_req both held continuously -> grant order D,D,D,D,F,D,D,D,D,F; no starvation.
//  4 Store word d_addr=0x020, d_wdata=0xDEADBEEF -> mem_rw=1, mem_wdata=0xDEADBEEF for 2 cycles,
//    d_ack pulse, d_err=0, d_rdata unchanged.
//  5 Load half d_addr=0x013 -> no mem_en, d_ack+d_err next cycle; then word load 0x014 -> d_err=0.
//  6 d_req dropped during ACCESS -> d_ack still pulses at cycle N+3; back to IDLE, no new access.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for the multi-cycle MIPS core: shares one RAM port between
// instruction fetch and data load/store, with fixed-latency access and one-cycle acknowledge.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned WaitW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e              state_q, state_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                sel_data_q, sel_data_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic grant_data, grant_fetch, starved, misaligned;
  logic [1:0] d_size_norm;

  always_comb begin
    starved     = if_req && (starve_q == StarveW'(STARVE_MAX));
    grant_data  = d_req && !starved;
    grant_fetch = if_req && !grant_data;
    // Size 11 behaves as a word access throughout.
    d_size_norm = {d_size[1], d_size[0] & ~d_size[1]};
    misaligned  = (d_size_norm == 2'b01 && d_addr[0]) ||
                  (d_size_norm == 2'b10 && d_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    starve_d   = starve_q;
    sel_data_d = sel_data_q;
    err_d      = err_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          sel_data_d = 1'b1;
          we_d       = d_we;
          size_d     = d_size_norm;
          addr_d     = d_addr;
          wdata_d    = d_wdata;
          err_d      = misaligned;
          wait_d     = '0;
          state_d    = misaligned ? StAck : StAccess;
          if (if_req && starve_q != StarveW'(STARVE_MAX)) begin
            starve_d = starve_q + StarveW'(1);
          end
        end else if (grant_fetch) begin
          sel_data_d = 1'b0;
          we_d       = 1'b0;
          size_d     = 2'b10;
          addr_d     = if_addr & ~ADDR_W'(3);
          err_d      = 1'b0;
          wait_d     = '0;
          starve_d   = '0;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        if (wait_q == WaitW'(MEM_LAT - 1)) begin
          wait_d  = '0;
          state_d = StAck;
          if (!we_q) begin
            if (sel_data_q) d_rdata_d  = mem_rdata;
            else            if_rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StAck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      starve_q   <= '0;
      sel_data_q <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      sel_data_q <= sel_data_d;
      err_q      <= err_d;
      we_q       <= we_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    mem_en    = (state_q == StAccess);
    busy      = (state_q != StIdle);
    if_ack    = (state_q == StAck) && !sel_data_q;
    d_ack     = (state_q == StAck) && sel_data_q;
    d_err     = d_ack && err_q;
    mem_rw    = we_q;
    mem_size  = size_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected transactions, a negedge
// monitor checks RAM-side signals and pops/compares on every acknowledge.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic              d_err;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ram_model(input logic [ADDR_W-1:0] a);
    return 32'h8C22_0000 | 32'(a);
  endfunction

  assign mem_rdata = ram_model(mem_addr);

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_size   (d_size),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_err    (d_err),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_rw   (mem_rw),
    .mem_size (mem_size),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  typedef struct {
    bit                is_data;
    bit                err;
    bit                rw;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                n_en;
  } exp_t;

  exp_t              q[$];
  int                checks = 0;
  int                errors = 0;
  int                en_cnt = 0;
  logic [DATA_W-1:0] last_d_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      en_cnt = 0;
    end else begin
      chk("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
      chk("err_without_ack", 32'(d_err & ~d_ack), 32'd0);
      if (mem_en) begin
        if (q.size() == 0) begin
          chk("unexpected_mem_en", 32'd1, 32'd0);
        end else begin
          chk("mem_rw", 32'(mem_rw), 32'(q[0].rw));
          chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
          chk("mem_size", 32'(mem_size), 32'(q[0].size));
          if (q[0].rw) chk("mem_wdata", mem_wdata, q[0].wdata);
        end
        en_cnt++;
      end
      if (if_ack || d_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("ack_port", 32'(d_ack), 32'(e.is_data));
          chk("d_err", 32'(d_err), 32'(e.err));
          chk("en_cycles", 32'(en_cnt), 32'(e.n_en));
          chk("rdata", e.is_data ? d_rdata : if_rdata, e.rdata);
        end
        en_cnt = 0;
      end
    end
  end

  task automatic mk_data(input bit we, input logic [1:0] size, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, output exp_t e);
    bit mis;
    mis = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    e.is_data = 1'b1;
    e.err     = mis;
    e.rw      = we;
    e.addr    = addr;
    e.size    = (size == 2'b11) ? 2'b10 : size;
    e.wdata   = wdata;
    e.n_en    = mis ? 0 : MEM_LAT;
    if (!we && !mis) last_d_rdata = ram_model(addr);
    e.rdata   = last_d_rdata;
  endtask

  task automatic mk_fetch(input logic [ADDR_W-1:0] addr, output exp_t e);
    e.is_data = 1'b0;
    e.err     = 1'b0;
    e.rw      = 1'b0;
    e.addr    = {addr[ADDR_W-1:2], 2'b00};
    e.size    = 2'b10;
    e.wdata   = '0;
    e.n_en    = MEM_LAT;
    e.rdata   = ram_model({addr[ADDR_W-1:2], 2'b00});
  endtask

  // Counts negedges from request assertion to acknowledge and drops both requests after it.
  task automatic wait_ack(input string name, input int lat_exp, input bit drop_at_en);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (drop_at_en && mem_en) d_req = 1'b0;
      if (if_ack || d_ack) got = 1'b1;
    end
    if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
    else      chk(name, 32'(n), 32'(lat_exp));
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  task automatic data_txn(input bit we, input logic [1:0] size, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int lat, input bit drop);
    exp_t e;
    @(posedge clk); #1;
    mk_data(we, size, addr, wdata, e);
    q.push_back(e);
    d_we = we; d_size = size; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    wait_ack("d_latency", lat, drop);
  endtask

  task automatic fetch_txn(input logic [ADDR_W-1:0] addr);
    exp_t e;
    @(posedge clk); #1;
    mk_fetch(addr, e);
    q.push_back(e);
    if_addr = addr; if_req = 1'b1;
    wait_ack("if_latency", 4, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    int   acks;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_size = 2'b10; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({if_ack, d_ack, d_err}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_bus", 32'({mem_rw, mem_size, mem_addr}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset in the middle of an access aborts it without an acknowledge.
    @(posedge clk); #1;
    mk_data(1'b0, 2'b10, 9'h010, '0, e);
    q.push_back(e);
    d_we = 1'b0; d_size = 2'b10; d_addr = 9'h010; d_req = 1'b1;
    n = 0;
    while (!mem_en && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_reached_access", 32'(mem_en), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; d_req = 1'b0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mid_d_ack", 32'(d_ack), 32'd0);
    chk("rst_mid_d_rdata", d_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_d_rdata = '0;

    fetch_txn(9'h004);
    fetch_txn(9'h00B);
    data_txn(1'b0, 2'b01, 9'h013, '0, 2, 1'b0);
    data_txn(1'b0, 2'b10, 9'h014, '0, 4, 1'b0);
    data_txn(1'b1, 2'b10, 9'h020, 32'hDEAD_BEEF, 4, 1'b0);
    data_txn(1'b0, 2'b10, 9'h022, '0, 2, 1'b0);
    data_txn(1'b0, 2'b00, 9'h013, '0, 4, 1'b0);
    data_txn(1'b0, 2'b11, 9'h018, '0, 4, 1'b0);
    data_txn(1'b1, 2'b01, 9'h02A, 32'h0000_1234, 4, 1'b0);

    // Request withdrawn during ACCESS still completes; no further access follows.
    data_txn(1'b0, 2'b10, 9'h024, '0, 4, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("post_drop_idle", 32'({busy, mem_en}), 32'd0);
    end

    // Both requesters held: fetch wins once every STARVE_MAX data grants.
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) mk_fetch(9'h008, e);
      else                  mk_data(1'b0, 2'b10, 9'h030, '0, e);
      q.push_back(e);
    end
    if_addr = 9'h008; if_req = 1'b1;
    d_we = 1'b0; d_size = 2'b10; d_addr = 9'h030; d_req = 1'b1;
    acks = 0;
    n    = 0;
    while (acks < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (if_ack || d_ack) acks++;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("contention_ack_count", 32'(acks), 32'd10);
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
